// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write tracker that gates issue
// into the register-file read stage. Stalls on RAW, WAW and in-flight limit.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN (a same-cycle writeback
// releases its register for hazard checks; requires a write-first regfile).
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic [4:0]          issue_rd,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic                issue_rd_we,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    inflight,
  output logic                full,
  output logic                err_wb_unpending
);

  localparam int unsigned IDX_W = 5;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic                wb_hit;
  logic                wb_err;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] eff_busy;
  logic [CNT_W-1:0]    eff_cnt;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                cap;
  logic                fire;
  logic                set_en;

  // Writeback classification, hazard terms and issue handshake.
  always_comb begin
    wb_hit   = wb_valid & (wb_rd != IDX_W'(0)) & busy_mask[wb_rd];
    wb_err   = wb_valid & (wb_rd != IDX_W'(0)) & ~busy_mask[wb_rd];
    clr_vec  = '0;
    if (wb_hit) clr_vec[wb_rd] = 1'b1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    // A register retiring this cycle is already visible as written.
    eff_busy = busy_mask & ~clr_vec;
    eff_cnt  = inflight - CNT_W'(wb_hit);
`else
    eff_busy = busy_mask;
    eff_cnt  = inflight;
`endif
    raw1 = issue_use_rs1 & (issue_rs1 != IDX_W'(0)) & eff_busy[issue_rs1];
    raw2 = issue_use_rs2 & (issue_rs2 != IDX_W'(0)) & eff_busy[issue_rs2];
    waw  = issue_rd_we & (issue_rd != IDX_W'(0)) & eff_busy[issue_rd];
    cap  = issue_rd_we & (issue_rd != IDX_W'(0)) & (eff_cnt == MAX_CNT);
    issue_ready = ~rst & ~flush & ~raw1 & ~raw2 & ~waw & ~cap;
    full        = ~rst & (inflight == MAX_CNT);
    fire        = issue_valid & issue_ready;
    set_en      = fire & issue_rd_we & (issue_rd != IDX_W'(0));
    set_vec     = '0;
    if (set_en) set_vec[issue_rd] = 1'b1;
  end

  // State update with priority rst > flush > set/clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask        <= '0;
      inflight         <= '0;
      err_wb_unpending <= 1'b0;
    end else if (flush) begin
      busy_mask <= '0;
      inflight  <= '0;
    end else begin
      busy_mask <= (busy_mask & ~clr_vec) | set_vec;
      inflight  <= inflight + CNT_W'(set_en) - CNT_W'(wb_hit);
      if (wb_err) err_wb_unpending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plus random stimulus against a register-set
// reference model; inflight is modelled as the population of pending registers.
module tb_regfile_scoreboard;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_use_rs1, issue_use_rs2, issue_rd_we;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        wb_valid, flush;
  logic        issue_ready, full, err_wb_unpending;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mbusy = '0;
  logic        merr = 1'b0;
  logic        known = 1'b0;

  regfile_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(MAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd_we(issue_rd_we), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .busy_mask(busy_mask), .inflight(inflight), .full(full),
    .err_wb_unpending(err_wb_unpending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected handshake from the hazard rules applied to the pending set.
  function automatic logic model_ready();
    logic [31:0] b;
    b = mbusy;
    if (rst || flush) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && wb_rd != 0 && b[wb_rd]) b[wb_rd] = 1'b0;
`endif
    if (issue_use_rs1 && issue_rs1 != 0 && b[issue_rs1]) return 1'b0;
    if (issue_use_rs2 && issue_rs2 != 0 && b[issue_rs2]) return 1'b0;
    if (issue_rd_we && issue_rd != 0 && b[issue_rd]) return 1'b0;
    if (issue_rd_we && issue_rd != 0 && $countones(b) == MAX) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle();
    rst = 0; flush = 0; issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
    issue_rd_we = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  // Check all outputs against the model, clock once, advance the model.
  task automatic tick();
    logic er;
    #1;
    er = model_ready();
    chk("issue_ready", 32'(issue_ready), 32'(er));
    if (rst || known)
      chk("full", 32'(full), (!rst && $countones(mbusy) == MAX) ? 32'd1 : 32'd0);
    if (known) begin
      chk("busy_mask", busy_mask, mbusy);
      chk("inflight", 32'(inflight), 32'($countones(mbusy)));
      chk("err_wb_unpending", 32'(err_wb_unpending), 32'(merr));
    end
    @(posedge clk);
    if (rst) begin
      mbusy = '0; merr = 1'b0; known = 1'b1;
    end else if (flush) begin
      mbusy = '0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (mbusy[wb_rd]) mbusy[wb_rd] = 1'b0;
        else merr = 1'b1;
      end
      if (issue_valid && er && issue_rd_we && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  initial begin
    int q[$];
    idle();
    rst = 1;
    tick();
    idle();

    // Basic set / RAW stall / writeback release.
    issue_valid = 1; issue_rd_we = 1; issue_rd = 5;
    tick();
    chk("tp1_busy", busy_mask, 32'h20);
    chk("tp1_inflight", 32'(inflight), 32'd1);
    idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5;
    #1 chk("tp1_raw_stall", 32'(issue_ready), 32'd0);
    tick();
    wb_valid = 1; wb_rd = 5;
    tick();
    wb_valid = 0;
    #1 chk("tp1_released", 32'(issue_ready), 32'd1);
    chk("tp1_inflight0", 32'(inflight), 32'd0);
    tick();

    // x0 is never tracked.
    idle(); issue_valid = 1; issue_rd_we = 1; issue_rd = 0;
    tick();
    idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 0;
    #1 chk("tp2_ready", 32'(issue_ready), 32'd1);
    tick();
    chk("tp2_busy", busy_mask, 32'h0);
    chk("tp2_inflight", 32'(inflight), 32'd0);

    // Capacity limit.
    idle();
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1; issue_rd_we = 1; issue_rd = 5'(i);
      tick();
    end
    idle();
    #1 chk("tp3_full", 32'(full), 32'd1);
    issue_valid = 1; issue_rd_we = 1; issue_rd = 6;
    #1 chk("tp3_cap_stall", 32'(issue_ready), 32'd0);
    tick();
    idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 7;
    #1 chk("tp3_nowrite_ok", 32'(issue_ready), 32'd1);
    tick();

    // Simultaneous set and clear of different registers.
    idle(); wb_valid = 1; wb_rd = 4;
    tick();
    idle(); issue_valid = 1; issue_rd_we = 1; issue_rd = 9; wb_valid = 1; wb_rd = 1;
    tick();
    idle();
    chk("tp4_busy", busy_mask, 32'h20C);
    chk("tp4_inflight", 32'(inflight), 32'd3);

    // Flush, then late writeback sets the sticky error.
    flush = 1;
    tick();
    idle(); issue_valid = 1; issue_rd_we = 1; issue_rd = 3;
    tick();
    issue_rd = 8;
    tick();
    idle(); flush = 1; wb_valid = 1; wb_rd = 3;
    tick();
    idle();
    chk("tp5_busy", busy_mask, 32'h0);
    chk("tp5_inflight", 32'(inflight), 32'd0);
    chk("tp5_err0", 32'(err_wb_unpending), 32'd0);
    wb_valid = 1; wb_rd = 8;
    tick();
    idle();
    chk("tp5_err1", 32'(err_wb_unpending), 32'd1);
    tick(); tick(); tick();
    flush = 1;
    tick();
    idle();
    chk("tp5_err_sticky", 32'(err_wb_unpending), 32'd1);
    rst = 1;
    tick();
    idle();
    chk("tp5_err_rst", 32'(err_wb_unpending), 32'd0);

    // Same-register writeback and reissue.
    issue_valid = 1; issue_rd_we = 1; issue_rd = 10;
    tick();
    idle(); wb_valid = 1; wb_rd = 10;
    issue_valid = 1; issue_use_rs2 = 1; issue_rs2 = 10; issue_rd_we = 1; issue_rd = 10;
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 chk("tp6_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    chk("tp6_busy", busy_mask, 32'h400);
    chk("tp6_inflight", 32'(inflight), 32'd1);
`else
    #1 chk("tp6_ready", 32'(issue_ready), 32'd0);
    tick();
    idle();
    chk("tp6_busy", busy_mask, 32'h0);
    chk("tp6_inflight", 32'(inflight), 32'd0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 29) == 0);
      issue_valid   = ($urandom_range(0, 9) < 7);
      issue_use_rs1 = 1'($urandom);
      issue_use_rs2 = 1'($urandom);
      issue_rd_we   = ($urandom_range(0, 3) != 0);
      issue_rs1     = 5'($urandom_range(0, 7));
      issue_rs2     = 5'($urandom_range(0, 7));
      issue_rd      = 5'($urandom_range(0, 7));
      wb_valid      = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int i = 1; i < 32; i++) if (mbusy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 7) != 0)
        wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wb_rd = 5'($urandom_range(0, 7));
      tick();
    end

    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
